// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder
//  Purpose  : Instruction-memory responder for a fetch stage. A read request
//             seen in IDLE is captured, held for LATENCY cycles and answered
//             with a one-cycle MEM_valid_o strobe carrying the addressed
//             32-bit word. A separate program-load port writes the array in
//             any state.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BITSIZE  address width of the request and load ports
//             (must be at least $clog2(DEPTH)+2)
//    DEPTH    number of 32-bit words (power of two, >= 2)
//    LATENCY  cycles from the capture edge to the response cycle (1..15)
//  Ports
//    clk          clock, rising-edge active
//    resetn_i     asynchronous active-low reset
//    MEM_addr_i   byte address of the requested instruction
//    MEM_read_i   read request level
//    MEM_data_o   registered instruction word (held outside the response)
//    MEM_valid_o  single-cycle response strobe
//    MEM_err_o    access error flag, qualified by MEM_valid_o
//    load_we_i    program-load write enable
//    load_addr_i  program-load byte address
//    load_data_i  program-load write data
//  Configuration
//    IMEM_RESPONDER_ERR_EN  when defined, misaligned or out-of-range reads
//                           flag MEM_err_o, out-of-range reads return zero
//                           and out-of-range load writes are dropped. When
//                           undefined, MEM_err_o is 0 and out-of-range
//                           addresses wrap modulo DEPTH.
// ============================================================================
module imem_responder #(
  parameter int BITSIZE = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic [BITSIZE-1:0] MEM_addr_i,
  input  logic               MEM_read_i,
  output logic [31:0]        MEM_data_o,
  output logic               MEM_valid_o,
  output logic               MEM_err_o,
  input  logic               load_we_i,
  input  logic [BITSIZE-1:0] load_addr_i,
  input  logic [31:0]        load_data_i
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q,   cnt_d;
  logic [BITSIZE-1:0] addr_q,  addr_d;
  logic [31:0]        data_q,  data_d;
  logic               valid_q, valid_d;
  logic               err_q,   err_d;

  // Instruction array; intentionally not reset so a loaded program survives.
  logic [31:0]        mem_q [DEPTH];

  logic [BITSIZE-1:0] rd_addr;
  logic [AW-1:0]      rd_idx;
  logic [AW-1:0]      wr_idx;
  logic [31:0]        rd_word;
  logic               rd_err;
  logic               mem_we;
  logic               enter_resp;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (MEM_read_i) begin
          addr_d  = MEM_addr_i;
          // With LATENCY=1 the array is read on the capture edge itself, so
          // the read index must come straight from the request port.
          rd_addr = MEM_addr_i;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Request inputs are ignored here: the captured address is used and
        // dropping MEM_read_i does not cancel the pending response.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Always one idle cycle between responses; MEM_read_i is ignored.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RESP is only ever entered from IDLE or WAIT, so state_d==RESP marks the
  // edge that enters it.
  assign enter_resp = (state_d == ST_RESP);

  // --------------------------------------------------------------------------
  // Array indexing and access checking
  // --------------------------------------------------------------------------
  assign rd_idx = rd_addr[AW+1:2];
  assign wr_idx = load_addr_i[AW+1:2];

`ifdef IMEM_RESPONDER_ERR_EN
  logic rd_misaligned;
  logic rd_oor;
  logic wr_oor;

  assign rd_misaligned = |rd_addr[1:0];
  // Any set bit above the word-index field means the byte address is at or
  // beyond DEPTH*4.
  assign rd_oor  = (rd_addr     >> (AW + 2)) != '0;
  assign wr_oor  = (load_addr_i >> (AW + 2)) != '0;
  assign rd_err  = rd_misaligned | rd_oor;
  assign rd_word = rd_oor ? 32'h0 : mem_q[rd_idx];
  assign mem_we  = load_we_i & ~wr_oor;
`else
  // Upper address bits are simply dropped, so accesses wrap modulo DEPTH.
  assign rd_err  = 1'b0;
  assign rd_word = mem_q[rd_idx];
  assign mem_we  = load_we_i;
`endif

  // Byte-offset bits and wrapped upper bits are deliberately not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q, rd_addr, load_addr_i};

  // --------------------------------------------------------------------------
  // Response register next-state
  // --------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (enter_resp) begin
      // rd_word is the pre-edge array content, so a load write on this same
      // edge to the same word is not visible in this response.
      data_d  = rd_word;
      valid_d = 1'b1;
      err_d   = rd_err;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Program-load write port, active in every FSM state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= load_data_i;
    end
  end

  assign MEM_data_o  = data_q;
  assign MEM_valid_o = valid_q;
  assign MEM_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_responder
//  Purpose  : Self-checking bench for imem_responder. Three instances with
//             LATENCY 1, 3 and 4 share one set of inputs; a transaction-level
//             model predicts each instance's response per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;
`ifdef IMEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn_i = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] data_w  [NI];
  logic        valid_w [NI];
  logic        err_w   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    imem_responder #(
      .BITSIZE(32),
      .DEPTH  (DEPTH),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk        (clk),
      .resetn_i   (resetn_i),
      .MEM_addr_i (mem_addr),
      .MEM_read_i (mem_read),
      .MEM_data_o (data_w[g]),
      .MEM_valid_o(valid_w[g]),
      .MEM_err_o  (err_w[g]),
      .load_we_i  (load_we),
      .load_addr_i(load_addr),
      .load_data_i(load_data)
    );
  end

  // --------------------------------------------------------------------------
  // Reference model: a request accepted at edge k owns the instance for edges
  // k..k+L; its strobe is launched by edge k+L-1 with the memory content as
  // it stood before that edge's load write.
  // --------------------------------------------------------------------------
  logic [31:0] ref_mem [DEPTH];
  bit          m_busy  [NI];
  int          m_cap   [NI];
  logic [31:0] m_addr  [NI];
  logic        exp_valid [NI];
  logic [31:0] exp_data  [NI];
  logic        exp_err   [NI];
  int          ecount;
  int          n_total;
  int          n_bad;

  function automatic int lat(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic bit in_range(logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    if (ERR_EN && !in_range(a)) return 32'h0;
    return ref_mem[word_of(a)];
  endfunction

  function automatic logic ref_err(logic [31:0] a);
    return ERR_EN && ((a % 4 != 0) || !in_range(a));
  endfunction

  function automatic bit wr_ok(logic [31:0] a);
    return !ERR_EN || in_range(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_busy[i]    = 1'b0;
      exp_valid[i] = 1'b0;
      exp_data[i]  = 32'h0;
      exp_err[i]   = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ecount++;
    for (int i = 0; i < NI; i++) begin
      exp_valid[i] = 1'b0;
      if (!resetn_i) begin
        m_busy[i]   = 1'b0;
        exp_data[i] = 32'h0;
        exp_err[i]  = 1'b0;
        continue;
      end
      if (m_busy[i] && ecount > m_cap[i] + lat(i)) m_busy[i] = 1'b0;
      if (!m_busy[i] && mem_read) begin
        m_busy[i] = 1'b1;
        m_cap[i]  = ecount;
        m_addr[i] = mem_addr;
      end
      if (m_busy[i] && ecount == m_cap[i] + lat(i) - 1) begin
        exp_valid[i] = 1'b1;
        exp_data[i]  = ref_read(m_addr[i]);
        exp_err[i]   = ref_err(m_addr[i]);
      end
    end
    if (load_we && wr_ok(load_addr)) ref_mem[word_of(load_addr)] = load_data;
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    mem_read = 1'b0; mem_addr = 32'h0;
    load_we = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    #2 resetn_i = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      n_total++;
      if (valid_w[i] !== 1'b0 || data_w[i] !== 32'h0 || err_w[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_async lat=%0d: got v=%b d=%h e=%b, want all zero",
                 lat(i), valid_w[i], data_w[i], err_w[i]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 3) resetn_i = 1'b1;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL reset_hold lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
    end
  endtask

  task automatic test_preload();
    for (int w = 0; w < DEPTH; w++) begin
      load_we = 1'b1; load_addr = w * 4; load_data = $urandom;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL preload lat=%0d t=%0d: got v=%b d=%h, want v=%b d=%h",
                   lat(i), ecount, valid_w[i], data_w[i], exp_valid[i], exp_data[i]);
        end
      end
    end
    load_we = 1'b0;
  endtask

  // LATENCY=1 fetch held high: strobe every other cycle with the loaded word.
  task automatic test_lat1_fetch();
    load_we = 1'b1; load_addr = 32'h0; load_data = 32'h0000_0013;
    mem_read = 1'b0; mem_addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
      tick();
      load_we  = 1'b0;
      mem_read = (c < 4);
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL lat1_fetch lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
      if (c >= 1 && c <= 4) begin
        n_total++;
        if (valid_w[0] !== c[0] || (c[0] && data_w[0] !== 32'h0000_0013)) begin
          n_bad++;
          $display("FAIL lat1_pattern c=%0d: got v=%b d=%h, want v=%b d=00000013",
                   c, valid_w[0], data_w[0], c[0]);
        end
      end
    end
    mem_read = 1'b0;
  endtask

  // Address change and read drop during WAIT must not disturb the request.
  task automatic test_wait_ignore();
    int nv = 0;
    int at = -1;
    logic [31:0] dv = 32'h0;
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: begin load_we = 1'b1; load_addr = 32'h8; load_data = 32'hA5A5_0008; end
        1: begin load_we = 1'b1; load_addr = 32'hC; load_data = 32'hC0C0_000C; end
        2: begin load_we = 1'b0; mem_read = 1'b1; mem_addr = 32'h8; end
        3: begin mem_read = 1'b0; mem_addr = 32'hC; end
        default: ;
      endcase
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL wait_ignore lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
      if (c >= 2 && valid_w[1] === 1'b1) begin
        nv++; at = c; dv = data_w[1];
      end
    end
    // Captured at edge 2; strobe launched by edge 4, seen by the fetch stage
    // at edge 5, three cycles after capture.
    n_total++;
    if (nv != 1 || at != 4 || dv !== 32'hA5A5_0008) begin
      n_bad++;
      $display("FAIL lat3_single_valid: got count=%0d edge=%0d d=%h, want count=1 edge=4 d=a5a50008",
               nv, at, dv);
    end
  endtask

  // Load write into the captured word while waiting: new data is returned.
  task automatic test_write_in_wait();
    logic [31:0] dv = 32'h0;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin load_we = 1'b1; load_addr = 32'h10; load_data = 32'h1111_1111; end
        1: begin load_we = 1'b0; mem_read = 1'b1; mem_addr = 32'h10; end
        2: begin mem_read = 1'b0; load_we = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF; end
        3: load_we = 1'b0;
        default: ;
      endcase
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL write_in_wait lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
      if (valid_w[1] === 1'b1) dv = data_w[1];
    end
    n_total++;
    if (dv !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL lat3_write_in_wait: got d=%h, want deadbeef", dv);
    end
  endtask

  // Write on the edge that enters RESP returns old data; one edge earlier
  // (the LATENCY=4 instance is still waiting) returns new data.
  task automatic test_write_on_resp();
    logic [31:0] d3 = 32'h0;
    logic [31:0] d4 = 32'h0;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin load_we = 1'b1; load_addr = 32'h20; load_data = 32'h2222_2222; end
        1: begin load_we = 1'b0; mem_read = 1'b1; mem_addr = 32'h20; end
        2: mem_read = 1'b0;
        3: begin load_we = 1'b1; load_addr = 32'h20; load_data = 32'h3333_3333; end
        4: load_we = 1'b0;
        default: ;
      endcase
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL write_on_resp lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
      if (valid_w[1] === 1'b1) d3 = data_w[1];
      if (valid_w[2] === 1'b1) d4 = data_w[2];
    end
    n_total++;
    if (d3 !== 32'h2222_2222) begin
      n_bad++;
      $display("FAIL same_edge_write_old: got d=%h, want 22222222", d3);
    end
    n_total++;
    if (d4 !== 32'h3333_3333) begin
      n_bad++;
      $display("FAIL earlier_write_new: got d=%h, want 33333333", d4);
    end
  endtask

  // Reset two cycles after a LATENCY=4 capture aborts the request.
  task automatic test_reset_abort();
    for (int c = 0; c < 3; c++) begin
      mem_read = (c == 0); mem_addr = 32'h8;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL pre_abort lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
    end
    mem_read = 1'b0;
    resetn_i = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      n_total++;
      if (valid_w[i] !== 1'b0 || data_w[i] !== 32'h0 || err_w[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_async lat=%0d: got v=%b d=%h e=%b, want all zero",
                 lat(i), valid_w[i], data_w[i], err_w[i]);
      end
    end
    tick();
    resetn_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_total++;
      if (valid_w[2] !== 1'b0 || data_w[2] !== 32'h0 || err_w[2] !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_valid c=%0d: got v=%b d=%h e=%b, want all zero",
                 c, valid_w[2], data_w[2], err_w[2]);
      end
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL post_abort lat=%0d t=%0d: got v=%b d=%h, want v=%b d=%h",
                   lat(i), ecount, valid_w[i], data_w[i], exp_valid[i], exp_data[i]);
        end
      end
    end
  endtask

  // Misaligned / beyond-array reads: error flag or wrap depending on build.
  // Word 0 holds 0x13 from the LATENCY=1 scenario.
  task automatic test_err();
    logic [31:0] want_d;
    want_d = ERR_EN ? 32'h0 : 32'h0000_0013;
    for (int c = 0; c < 14; c++) begin
      mem_read = (c == 0) || (c == 7);
      mem_addr = (c < 7) ? 32'h1002 : 32'h1000;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL err_model lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
      if (c == 0 || c == 7) begin
        n_total++;
        if (valid_w[0] !== 1'b1 || err_w[0] !== ERR_EN || data_w[0] !== want_d) begin
          n_bad++;
          $display("FAIL err_directed addr=%h: got v=%b d=%h e=%b, want v=1 d=%h e=%b",
                   mem_addr, valid_w[0], data_w[0], err_w[0], want_d, ERR_EN);
        end
      end
    end
    mem_read = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      mem_read  = ($urandom_range(0, 9) < 7);
      mem_addr  = $urandom_range(0, 8191);
      load_we   = ($urandom_range(0, 3) == 0);
      load_addr = $urandom_range(0, 8191);
      load_data = $urandom;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_total++;
        if (valid_w[i] !== exp_valid[i] || data_w[i] !== exp_data[i] ||
            (exp_valid[i] && err_w[i] !== exp_err[i])) begin
          n_bad++;
          $display("FAIL random lat=%0d t=%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   lat(i), ecount, valid_w[i], data_w[i], err_w[i],
                   exp_valid[i], exp_data[i], exp_err[i]);
        end
      end
    end
    mem_read = 1'b0;
    load_we  = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    ecount  = 0;
    test_reset();
    test_preload();
    test_lat1_fetch();
    test_wait_ignore();
    test_write_in_wait();
    test_write_on_resp();
    test_reset_abort();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter BITSIZE, default 32: address width of the request and load ports.
REQ-002 Parameter DEPTH, default 1024: number of 32-bit words in the array; power of two, at least 2.
REQ-003 Parameter LATENCY, default 1: cycles from the request capture edge to the response cycle; range 1..15.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 resetn_i  input  1  reset, asynchronous, active-low.
REQ-006 MEM_addr_i  input  BITSIZE  byte address of the requested instruction.
REQ-007 MEM_read_i  input  1  read request level; the fetch stage holds it high while it wants a word.
REQ-008 MEM_data_o  output  32  instruction word; registered.
REQ-009 MEM_valid_o  output  1  single-cycle response strobe qualifying MEM_data_o and MEM_err_o.
REQ-010 MEM_err_o  output  1  access error flag; meaningful only while MEM_valid_o=1.
REQ-011 load_we_i  input  1  program-load write enable.
REQ-012 load_addr_i  input  BITSIZE  program-load byte address.
REQ-013 load_data_i  input  32  program-load write data.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with MEM_read_i=1 at a rising edge, the block SHALL capture MEM_addr_i and load the counter with LATENCY-1.
REQ-016 On that capture edge the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT.
REQ-017 In WAIT the counter SHALL decrement by one each edge; the FSM SHALL go to RESP on the edge where the counter is 1.
REQ-018 On the edge entering RESP, the block SHALL register array[idx] into MEM_data_o, where idx = captured address bits [log2(DEPTH)+1:2].
REQ-019 MEM_valid_o SHALL be 1 exactly in the RESP cycle, so the response appears LATENCY cycles after the capture edge.
REQ-020 RESP SHALL always return to IDLE; MEM_read_i is ignored in RESP, giving at least one idle cycle between responses.
REQ-021 Changes on MEM_addr_i or MEM_read_i during WAIT SHALL have no effect: the captured address is used, and a deasserted read does not cancel the request.
REQ-022 Address bits [1:0] SHALL be ignored for indexing (misaligned addresses are truncated to the word).
REQ-023 A load_we_i=1 edge SHALL write load_data_i to array[load_addr_i index] in any FSM state.
REQ-024 Write during WAIT to the captured word: the response SHALL return the new data.
REQ-025 Write on the same edge that enters RESP, to the same word: the response SHALL return the old data.
REQ-026 MEM_data_o SHALL hold its last value outside RESP.

Reset
REQ-027 On resetn_i=0 the block SHALL immediately set: state IDLE, counter 0, MEM_valid_o 0, MEM_data_o 0, MEM_err_o 0.
REQ-028 Array contents SHALL NOT be reset.
REQ-029 A reset during WAIT or RESP SHALL abort the request; no MEM_valid_o is produced for it after reset release.
REQ-030 The first capture SHALL occur on the first rising edge with resetn_i=1 and MEM_read_i=1.

Configuration
REQ-031 The macro IMEM_RESPONDER_ERR_EN SHALL enable access error checking.
REQ-032 With IMEM_RESPONDER_ERR_EN defined, MEM_err_o SHALL be 1 in RESP when the captured address has bits[1:0] != 0 or is >= DEPTH*4.
REQ-033 With IMEM_RESPONDER_ERR_EN defined, an out-of-range read SHALL return MEM_data_o=0, and an out-of-range load write SHALL be dropped.
REQ-034 Without IMEM_RESPONDER_ERR_EN, MEM_err_o SHALL be constant 0.
REQ-035 Without IMEM_RESPONDER_ERR_EN, out-of-range addresses SHALL wrap (index modulo DEPTH) for both reads and load writes.

Verification
REQ-036 LATENCY=1: load word 0x00000013 at 0x0, then hold read with addr 0x0 -> MEM_valid_o=1 with data 0x00000013 in the cycle after capture; next capture 2 cycles later.
REQ-037 LATENCY=3: capture addr 0x8, then change addr to 0xC and drop read during WAIT -> exactly one valid, 3 cycles after capture, carrying the word at 0x8.
REQ-038 LATENCY=3: capture 0x10, then load-write 0xDEADBEEF to 0x10 during WAIT -> response data 0xDEADBEEF.
REQ-039 LATENCY=4: reset pulse 2 cycles after capture -> no valid for 6 cycles after reset release while read=0; all outputs 0.
REQ-040 ERR_EN defined, DEPTH=1024: read 0x1002 -> err=1; read 0x1000 -> err=1, data=0. ERR_EN undefined: read 0x1000 -> data of word 0, err=0.
